// File: rtl/lock_attempt_governor.sv
// Purpose: brute-force guard between the keypad and the lock; blocks keys for a doubling penalty after repeated failures.
// Latency: key_out follows key_in with one cycle of register delay; status outputs are registered.
// Backpressure: none; keys presented while blocked are dropped, and a key held through a lockout must be released first.
module lock_attempt_governor #(
    parameter longint unsigned CLOCK_FREQ   = 50000000,
    parameter longint unsigned LOCKOUT_BASE = 30 * CLOCK_FREQ,
    parameter int              MAX_FAILS    = 3,
    parameter int              MAX_LEVEL    = 3,
    parameter int              KEY_WIDTH    = 4,
    parameter int              FAIL_WIDTH   = $clog2(MAX_FAILS + 1),
    parameter int              LEVEL_WIDTH  = $clog2(MAX_LEVEL + 1),
    parameter int              CNT_WIDTH    = $clog2((LOCKOUT_BASE << MAX_LEVEL) + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic                   locked,
    input  logic                   error,
    output logic [KEY_WIDTH-1:0]   key_out,
    output logic                   lockout,
    output logic [FAIL_WIDTH-1:0]  fail_count,
    output logic [LEVEL_WIDTH-1:0] penalty_level
);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        LOCKOUT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [FAIL_WIDTH-1:0]  FAIL_LAST = FAIL_WIDTH'(MAX_FAILS - 1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [KEY_WIDTH-1:0]   NO_KEY    = '0;

    state_t               state;
    logic [CNT_WIDTH-1:0] counter;
    logic                 error_d;
    logic                 locked_d;
    logic                 fail_evt;
    logic                 ok_evt;

    // A held error counts once; any change of the lock state is a successful entry.
    assign fail_evt = error & ~error_d;
    assign ok_evt   = locked ^ locked_d;

    // Edge-detect registers track their inputs in every state, so nothing is
    // mistaken for a fresh edge when the governor re-arms.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_d  <= 1'b0;
            locked_d <= 1'b0;
        end else begin
            error_d  <= error;
            locked_d <= locked;
        end
    end

    // Governor FSM: failure counting, penalty timing and key gating.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ARMED;
            counter       <= '0;
            key_out       <= NO_KEY;
            lockout       <= 1'b0;
            fail_count    <= '0;
            penalty_level <= '0;
        end else begin
            case (state)
                ARMED: begin
                    if (ok_evt) begin
                        // A success wins over a coincident failure edge.
                        fail_count    <= '0;
                        penalty_level <= '0;
                        key_out       <= key_in;
                    end else if (fail_evt && (fail_count == FAIL_LAST)) begin
                        state      <= LOCKOUT;
                        counter    <= CNT_WIDTH'(LOCKOUT_BASE << penalty_level);
                        fail_count <= '0;
                        if (penalty_level != LEVEL_TOP) begin
                            penalty_level <= penalty_level + 1'b1;
                        end
                        lockout    <= 1'b1;
                        key_out    <= NO_KEY;
                    end else begin
                        if (fail_evt) begin
                            fail_count <= fail_count + 1'b1;
                        end
                        key_out <= key_in;
                    end
                end
                LOCKOUT: begin
                    // Lock results are ignored while the penalty runs.
                    key_out <= NO_KEY;
                    if (counter <= 1) begin
                        counter <= '0;
                        lockout <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RELEASE: begin
                    // Wait for an idle keypad so a key held through the
                    // penalty is not delivered as a new press.
                    key_out <= NO_KEY;
                    if (ok_evt) begin
                        fail_count    <= '0;
                        penalty_level <= '0;
                    end
                    if (key_in == NO_KEY) begin
                        state <= ARMED;
                    end
                end
                default: begin
                    state   <= ARMED;
                    counter <= '0;
                    key_out <= NO_KEY;
                    lockout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_attempt_governor.sv
// Purpose: self-checking bench for lock_attempt_governor with a short penalty base.
// Latency: expects key_out and status one clock after the inputs are presented.
// Backpressure: not applicable; the bench drives every cycle.
module tb_lock_attempt_governor;

    logic       clock;
    logic       reset;
    logic [3:0] key_in;
    logic       locked;
    logic       error;
    logic [3:0] key_out;
    logic       lockout;
    logic [1:0] fail_count;
    logic [1:0] penalty_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] key_in;
        logic       error;
        logic       locked;
        logic [3:0] exp_key;
        logic       exp_lockout;
        logic [1:0] exp_fails;
        logic [1:0] exp_level;
    } vec_t;

    typedef struct {
        logic [3:0] key;
        logic       lockout;
        logic [1:0] fails;
        logic [1:0] level;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    lock_attempt_governor #(
        .CLOCK_FREQ  (100),
        .LOCKOUT_BASE(8),
        .MAX_FAILS   (3),
        .MAX_LEVEL   (2),
        .KEY_WIDTH   (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_in       (key_in),
        .locked       (locked),
        .error        (error),
        .key_out      (key_out),
        .lockout      (lockout),
        .fail_count   (fail_count),
        .penalty_level(penalty_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case a wait is ever left unbounded by mistake.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One error pulse: one cycle high, five low.
    task automatic fail_pulse(input logic [1:0] exp_fc, input string tag);
        error = 1'b1;
        step();
        check({tag, " fail_count"}, 32'(fail_count), 32'(exp_fc));
        error = 1'b0;
        repeat (5) step();
    endtask

    // Three-failure burst with a key held through the penalty, then the
    // release/re-press sequence.
    task automatic do_lockout(input int exp_len, input logic [1:0] exp_lv, input string tag);
        int n;
        int leaks;
        fail_pulse(2'd1, {tag, " pulse1"});
        fail_pulse(2'd2, {tag, " pulse2"});
        error  = 1'b1;
        key_in = 4'h5;
        step();
        error = 1'b0;
        check({tag, " lockout rise"}, 32'(lockout), 32'd1);
        check({tag, " fail_count cleared"}, 32'(fail_count), 32'd0);
        check({tag, " penalty_level"}, 32'(penalty_level), 32'(exp_lv));
        n     = (lockout === 1'b1) ? 1 : 0;
        leaks = (key_out !== 4'h0) ? 1 : 0;
        while (lockout === 1'b1 && n < 200) begin
            step();
            if (lockout === 1'b1) n++;
            if (key_out !== 4'h0) leaks++;
        end
        check({tag, " lockout length"}, 32'(n), 32'(exp_len));
        check({tag, " key leaks during lockout"}, 32'(leaks), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, " held key after lockout"}, 32'(key_out), 32'd0);
        end
        key_in = 4'h0;
        step();
        check({tag, " key released"}, 32'(key_out), 32'd0);
        key_in = 4'h5;
        step();
        check({tag, " new press"}, 32'(key_out), 32'h5);
        key_in = 4'h0;
        step();
    endtask

    initial begin
        exp_t got;
        exp_t want;

        // key, err, lock -> key_out, lockout, fail_count, penalty_level
        vecs[0]  = '{4'h2, 1'b0, 1'b0, 4'h2, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{4'h7, 1'b1, 1'b0, 4'h7, 1'b0, 2'd1, 2'd0};
        vecs[3]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 2'd0};
        vecs[4]  = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 2'd0};
        vecs[5]  = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 2'd0};
        vecs[6]  = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 2'd0};
        vecs[7]  = '{4'h3, 1'b0, 1'b1, 4'h3, 1'b0, 2'd0, 2'd0};
        vecs[8]  = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 2'd0};
        vecs[9]  = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd1, 2'd0};
        vecs[10] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0};
        vecs[11] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0};

        reset  = 1'b1;
        key_in = 4'h0;
        locked = 1'b0;
        error  = 1'b0;
        repeat (3) step();
        check("reset key_out", 32'(key_out), 32'd0);
        check("reset lockout", 32'(lockout), 32'd0);
        check("reset fail_count", 32'(fail_count), 32'd0);
        check("reset penalty_level", 32'(penalty_level), 32'd0);
        reset = 1'b0;
        step();

        // Table-driven single-cycle behaviour through a scoreboard queue.
        for (int i = 0; i < 12; i++) begin
            key_in = vecs[i].key_in;
            error  = vecs[i].error;
            locked = vecs[i].locked;
            sb.push_back('{vecs[i].exp_key, vecs[i].exp_lockout, vecs[i].exp_fails, vecs[i].exp_level});
            step();
            got  = '{key_out, lockout, fail_count, penalty_level};
            want = sb.pop_front();
            check($sformatf("vec%0d key_out", i), 32'(got.key), 32'(want.key));
            check($sformatf("vec%0d lockout", i), 32'(got.lockout), 32'(want.lockout));
            check($sformatf("vec%0d fail_count", i), 32'(got.fails), 32'(want.fails));
            check($sformatf("vec%0d penalty_level", i), 32'(got.level), 32'(want.level));
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        // Repeated lockouts: penalty doubles and saturates.
        do_lockout(8,  2'd1, "lk1");
        do_lockout(16, 2'd2, "lk2");
        do_lockout(32, 2'd2, "lk3");
        do_lockout(32, 2'd2, "lk4");

        // A success clears the failure count and the penalty level.
        fail_pulse(2'd1, "ok pulse1");
        fail_pulse(2'd2, "ok pulse2");
        locked = ~locked;
        step();
        check("ok clears fail_count", 32'(fail_count), 32'd0);
        check("ok clears penalty_level", 32'(penalty_level), 32'd0);
        error  = 1'b1;
        locked = ~locked;
        step();
        check("ok beats fail", 32'(fail_count), 32'd0);
        error = 1'b0;
        repeat (2) step();

        // Reset in the middle of a lockout.
        fail_pulse(2'd1, "rst pulse1");
        fail_pulse(2'd2, "rst pulse2");
        error = 1'b1;
        step();
        error = 1'b0;
        check("rst lockout entered", 32'(lockout), 32'd1);
        repeat (3) step();
        check("rst still locked out", 32'(lockout), 32'd1);
        reset = 1'b1;
        #1;
        check("async reset lockout", 32'(lockout), 32'd0);
        check("async reset key_out", 32'(key_out), 32'd0);
        check("async reset penalty_level", 32'(penalty_level), 32'd0);
        repeat (2) step();
        reset  = 1'b0;
        key_in = 4'h1;
        step();
        check("post reset key_out", 32'(key_out), 32'h1);
        key_in = 4'h0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
